// File: rtl/digit_serial_adder_pkg.sv
// Shared types and elaboration helpers for the digit-serial adder.
package digit_serial_adder_pkg;

  // Controller states: IDLE waits for start, RUN processes one digit per
  // cycle, DONE presents the result for exactly one cycle.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Number of digits needed to cover the operand width.
  function automatic int calc_ndig(input int width, input int digit);
    if (digit > 0) begin
      return width / digit;
    end else begin
      return 0;
    end
  endfunction

  // Width of a counter able to index every digit (at least one bit).
  function automatic int calc_cnt_w(input int ndig);
    if (ndig > 1) begin
      return $clog2(ndig);
    end else begin
      return 1;
    end
  endfunction

endpackage

// File: rtl/digit_serial_adder_if.sv
// Request/result bundle between a client and the digit-serial adder.
interface digit_serial_adder_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic             sub;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, a, b,
    input  busy, done, sum, cout, ovf
  );

  modport slave (
    input  start, sub, a, b,
    output busy, done, sum, cout, ovf
  );
endinterface

// File: rtl/digit_serial_adder_adder_digit.sv
// One digit of the adder: a DIGIT-bit ripple of full adders. cmsb is the
// carry into the top bit, used with cout to detect signed overflow.
module adder_digit #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [DIGIT:0] c_s;

  // Ripple the carry through DIGIT full adders.
  always_comb begin
    c_s    = '0;
    s      = '0;
    c_s[0] = cin;
    for (int i = 0; i < DIGIT; i++) begin
      s[i]     = x[i] ^ y[i] ^ c_s[i];
      c_s[i+1] = (x[i] & y[i]) | (c_s[i] & (x[i] ^ y[i]));
    end
  end

  assign cout = c_s[DIGIT];
  assign cmsb = c_s[DIGIT-1];

endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: consumes DIGIT bits of each operand per
// cycle, LSB first, and shifts the result in from the MSB side so that the
// full sum is aligned once the last digit has been processed.
module digit_serial_adder
  import digit_serial_adder_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic          clock,
  input  logic          resetn,
  digit_serial_adder_if.slave bus
);

  localparam int NDIG  = calc_ndig(WIDTH, DIGIT);
  localparam int CNT_W = calc_cnt_w(NDIG);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  if ((DIGIT < 1) || (WIDTH < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $fatal(1, "digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
  end

  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   load_s;
  logic                   step_s;
  logic                   last_s;
  logic [WIDTH-1:0]       op_a_r;
  logic [WIDTH-1:0]       op_b_r;
  logic [WIDTH-1:0]       res_r;
  logic                   carry_r;
  logic                   cout_r;
  logic                   ovf_r;
  logic                   busy_r;
  logic                   done_r;
  logic [CNT_W-1:0]       cnt_r;
  logic [DIGIT-1:0]       dig_s;
  logic                   dig_cout_s;
  logic                   dig_cmsb_s;
  logic [WIDTH+DIGIT-1:0] res_cat_s;

  adder_digit #(
    .DIGIT(DIGIT)
  ) u_adder_digit (
    .x    (op_a_r[DIGIT-1:0]),
    .y    (op_b_r[DIGIT-1:0]),
    .cin  (carry_r),
    .s    (dig_s),
    .cout (dig_cout_s),
    .cmsb (dig_cmsb_s)
  );

  // New digit enters at the top; dropping the low DIGIT bits shifts the rest down.
  assign res_cat_s = {dig_s, res_r};

  // Next-state and datapath control; start is only honoured in IDLE/DONE.
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    step_s      = 1'b0;
    last_s      = (cnt_r == LAST_CNT);
    case (state_r)
      IDLE: begin
        if (bus.start) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (last_s) begin
          state_nxt_s = DONE;
        end else begin
          state_nxt_s = RUN;
        end
      end
      DONE: begin
        if (bus.start) begin
          load_s      = 1'b1;
          state_nxt_s = RUN;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase
  end

  // State register plus registered status flags decoded from the next state.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == RUN);
      done_r  <= (state_nxt_s == DONE);
    end
  end

  // Operand load on accepted start, then one digit per RUN cycle.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      op_a_r  <= '0;
      op_b_r  <= '0;
      res_r   <= '0;
      carry_r <= 1'b0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
      cnt_r   <= '0;
    end else if (load_s) begin
      // Subtract as a + ~b + 1: the +1 enters through the carry register.
      op_a_r  <= bus.a;
      op_b_r  <= bus.sub ? ~bus.b : bus.b;
      carry_r <= bus.sub;
      cnt_r   <= '0;
    end else if (step_s) begin
      op_a_r  <= op_a_r >> DIGIT;
      op_b_r  <= op_b_r >> DIGIT;
      res_r   <= res_cat_s[WIDTH+DIGIT-1:DIGIT];
      carry_r <= dig_cout_s;
      // Only the value left after the final digit matters for cout/ovf.
      cout_r  <= dig_cout_s;
      ovf_r   <= dig_cmsb_s ^ dig_cout_s;
      cnt_r   <= last_s ? '0 : (cnt_r + CNT_ONE);
    end
  end

  assign bus.busy = busy_r;
  assign bus.done = done_r;
  assign bus.sum  = res_r;
  assign bus.cout = cout_r;
  assign bus.ovf  = ovf_r;

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench: four 8-bit adders (DIGIT 1,2,4,8) share one stimulus
// stream, plus a 16-bit DIGIT=4 instance; all results are compared with a
// signed/unsigned arithmetic reference model.
module tb_digit_serial_adder;

  logic clock  = 1'b0;
  logic resetn = 1'b0;
  int   n_cmp  = 0;
  int   n_bad  = 0;

  always #5 clock = ~clock;

  logic       start_t = 1'b0;
  logic       sub_t   = 1'b0;
  logic [7:0] a_t     = 8'h00;
  logic [7:0] b_t     = 8'h00;
  logic [3:0] done_v;
  logic [3:0] busy_v;
  logic [3:0] cout_v;
  logic [3:0] ovf_v;
  logic [7:0] sum_v [4];

  for (genvar g = 0; g < 4; g++) begin : g_dut
    digit_serial_adder_if #(.WIDTH(8)) bus ();
    assign bus.start = start_t;
    assign bus.sub   = sub_t;
    assign bus.a     = a_t;
    assign bus.b     = b_t;
    assign done_v[g] = bus.done;
    assign busy_v[g] = bus.busy;
    assign cout_v[g] = bus.cout;
    assign ovf_v[g]  = bus.ovf;
    assign sum_v[g]  = bus.sum;
    digit_serial_adder #(.WIDTH(8), .DIGIT(1 << g)) u_dut (
      .clock  (clock),
      .resetn (resetn),
      .bus    (bus)
    );
  end

  logic        start16 = 1'b0;
  logic        sub16   = 1'b0;
  logic [15:0] a16     = 16'h0000;
  logic [15:0] b16     = 16'h0000;
  digit_serial_adder_if #(.WIDTH(16)) bus16 ();
  assign bus16.start = start16;
  assign bus16.sub   = sub16;
  assign bus16.a     = a16;
  assign bus16.b     = b16;
  digit_serial_adder #(.WIDTH(16), .DIGIT(4)) u_dut16 (
    .clock  (clock),
    .resetn (resetn),
    .bus    (bus16)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: plain modular/unsigned/signed arithmetic on the operands.
  function automatic void ref_model(input int w, input longint a, input longint b, input bit s,
                                    output longint rs, output bit rc, output bit rv);
    longint m, h, sa, sb, r;
    m  = longint'(1) << w;
    h  = m / 2;
    rs = s ? ((a - b + m) % m) : ((a + b) % m);
    rc = s ? (a >= b) : ((a + b) >= m);
    sa = (a >= h) ? a - m : a;
    sb = (b >= h) ? b - m : b;
    r  = s ? sa - sb : sa + sb;
    rv = (r < -h) || (r >= h);
  endfunction

  task automatic run_op8(input logic [7:0] a, input logic [7:0] b, input logic s);
    int         done_k [4];
    int         busy_n [4];
    logic [7:0] cs [4];
    logic       cc [4];
    logic       cv [4];
    longint     es;
    bit         ec, ev;
    string      tg;
    ref_model(8, longint'(a), longint'(b), s, es, ec, ev);
    for (int g = 0; g < 4; g++) begin
      done_k[g] = -1; busy_n[g] = 0; cs[g] = 8'hxx; cc[g] = 1'bx; cv[g] = 1'bx;
    end
    @(negedge clock);
    a_t = a; b_t = b; sub_t = s; start_t = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      for (int g = 0; g < 4; g++) begin
        if (busy_v[g]) busy_n[g]++;
        if (done_v[g]) begin
          if (done_k[g] < 0) begin
            done_k[g] = k; cs[g] = sum_v[g]; cc[g] = cout_v[g]; cv[g] = ovf_v[g];
          end else begin
            done_k[g] = 100;
          end
        end
      end
      if (k == 0) begin
        // Scramble inputs and pulse start mid-run: none of it may matter.
        start_t = 1'($urandom_range(0, 1));
        a_t = 8'($urandom); b_t = 8'($urandom); sub_t = 1'($urandom_range(0, 1));
      end else begin
        start_t = 1'b0;
      end
    end
    for (int g = 0; g < 4; g++) begin
      tg = $sformatf("d%0d %02h%s%02h", 1 << g, a, s ? "-" : "+", b);
      check({tg, " done_at"}, 64'(done_k[g]), 64'(8 >> g));
      check({tg, " busy_cycles"}, 64'(busy_n[g]), 64'(8 >> g));
      check({tg, " sum"}, 64'(cs[g]), 64'(es));
      check({tg, " cout"}, 64'(cc[g]), 64'(ec));
      check({tg, " ovf"}, 64'(cv[g]), 64'(ev));
      check({tg, " held_sum"}, 64'(sum_v[g]), 64'(es));
      check({tg, " held_flags"}, 64'({cout_v[g], ovf_v[g]}), 64'({ec, ev}));
    end
  endtask

  task automatic run_op16(input logic [15:0] a, input logic [15:0] b, input logic s);
    int          done_k;
    int          busy_n;
    logic [15:0] cs;
    logic        cc, cv;
    longint      es;
    bit          ec, ev;
    string       tg;
    ref_model(16, longint'(a), longint'(b), s, es, ec, ev);
    done_k = -1; busy_n = 0; cs = 16'hxxxx; cc = 1'bx; cv = 1'bx;
    @(negedge clock);
    a16 = a; b16 = b; sub16 = s; start16 = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clock);
      start16 = 1'b0;
      a16 = 16'($urandom); b16 = 16'($urandom);
      if (bus16.busy) busy_n++;
      if (bus16.done) begin
        if (done_k < 0) begin
          done_k = k; cs = bus16.sum; cc = bus16.cout; cv = bus16.ovf;
        end else begin
          done_k = 100;
        end
      end
    end
    tg = $sformatf("w16d4 %04h%s%04h", a, s ? "-" : "+", b);
    check({tg, " done_at"}, 64'(done_k), 64'(4));
    check({tg, " busy_cycles"}, 64'(busy_n), 64'(4));
    check({tg, " sum"}, 64'(cs), 64'(es));
    check({tg, " cout"}, 64'(cc), 64'(ec));
    check({tg, " ovf"}, 64'(cv), 64'(ev));
  endtask

  task automatic back_to_back();
    int         first, second;
    logic [7:0] s1, s2;
    logic       c1, v1;
    first = -1; second = -1; s1 = 8'h00; s2 = 8'h00; c1 = 1'b0; v1 = 1'b0;
    @(negedge clock);
    a_t = 8'h7F; b_t = 8'h01; sub_t = 1'b0; start_t = 1'b1;
    for (int k = 0; k < 30; k++) begin
      @(negedge clock);
      if (done_v[0]) begin
        if (first < 0) begin
          first = k; s1 = sum_v[0]; c1 = cout_v[0]; v1 = ovf_v[0];
          a_t = 8'h22; b_t = 8'h11;
        end else if (second < 0) begin
          second = k; s2 = sum_v[0];
          start_t = 1'b0;
        end
      end else if (first < 0 && k == 3) begin
        a_t = 8'hAA; b_t = 8'h55; sub_t = 1'b1;
      end else if (first >= 0 && second < 0) begin
        sub_t = 1'b1; a_t = 8'($urandom);
      end
      if (first >= 0 && second < 0 && !done_v[0]) begin
        b_t = 8'($urandom);
      end
      if (first >= 0 && k == first) begin
        sub_t = 1'b0;
      end
    end
    start_t = 1'b0;
    repeat (12) @(negedge clock);
    check("b2b first_done_at", 64'(first), 64'(8));
    check("b2b done_spacing", 64'(second - first), 64'(9));
    check("b2b sum1", 64'(s1), 64'(8'h80));
    check("b2b flags1", 64'({c1, v1}), 64'(2'b01));
    check("b2b sum2", 64'(s2), 64'(8'h33));
  endtask

  task automatic reset_mid_run();
    int seen;
    seen = 0;
    @(negedge clock);
    a_t = 8'h55; b_t = 8'h33; sub_t = 1'b0; start_t = 1'b1;
    @(negedge clock);
    start_t = 1'b0;
    repeat (3) @(negedge clock);
    #1 resetn = 1'b0;
    #1;
    check("rst busy", 64'(busy_v), 64'(0));
    check("rst done", 64'(done_v), 64'(0));
    check("rst cout", 64'(cout_v), 64'(0));
    check("rst ovf", 64'(ovf_v), 64'(0));
    check("rst sum", 64'({sum_v[0], sum_v[1], sum_v[2], sum_v[3]}), 64'(0));
    check("rst w16", 64'({bus16.sum, bus16.cout, bus16.ovf, bus16.busy, bus16.done}), 64'(0));
    #2 resetn = 1'b1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      if (done_v != 4'b0000 || busy_v != 4'b0000) seen++;
    end
    check("rst no_done_after", 64'(seen), 64'(0));
    run_op8(8'h10, 8'h20, 1'b0);
  endtask

  initial begin
    repeat (3) @(negedge clock);
    check("reset outputs", 64'({busy_v, done_v, cout_v, ovf_v}), 64'(0));
    check("reset sum", 64'({sum_v[0], sum_v[3], bus16.sum}), 64'(0));
    @(posedge clock);
    #2 resetn = 1'b1;
    run_op8(8'h7F, 8'h01, 1'b0);
    run_op8(8'h05, 8'h07, 1'b1);
    run_op8(8'h07, 8'h05, 1'b1);
    run_op8(8'h80, 8'h01, 1'b1);
    run_op8(8'hFF, 8'h01, 1'b0);
    run_op8(8'h00, 8'h00, 1'b1);
    run_op16(16'hFFFF, 16'h0001, 1'b0);
    run_op16(16'h8000, 16'h0001, 1'b1);
    back_to_back();
    reset_mid_run();
    for (int i = 0; i < 1000; i++) begin
      run_op8(8'($urandom), 8'($urandom), 1'($urandom_range(0, 1)));
    end
    for (int i = 0; i < 50; i++) begin
      run_op16(16'($urandom), 16'($urandom), 1'($urandom_range(0, 1)));
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/digit_serial_adder.md
DIGIT_SERIAL_ADDER -- requirements
Module: digit_serial_adder

Interface
REQ-001 Parameter WIDTH, default 8: operand and result width in bits.
REQ-002 Parameter DIGIT, default 1: bits processed per cycle; WIDTH SHALL be a positive multiple of DIGIT, and elaboration SHALL fail otherwise.
REQ-003 clock  input  1  single clock; all state changes on rising edge.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  request a new operation; sampled only in IDLE or DONE.
REQ-006 sub  input  1  0 = a+b, 1 = a-b; sampled with start.
REQ-007 a  input  WIDTH  first operand; sampled with start.
REQ-008 b  input  WIDTH  second operand; sampled with start.
REQ-009 busy  output  1  high while in RUN.
REQ-010 done  output  1  one-cycle pulse; result valid.
REQ-011 sum  output  WIDTH  result, held until the next accepted start.
REQ-012 cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
REQ-013 ovf  output  1  two's-complement overflow; held with sum.

Function
REQ-014 FSM states SHALL be IDLE, RUN and DONE; NDIG = WIDTH/DIGIT.
REQ-015 In IDLE or DONE, start=1 on an edge SHALL:
  - latch a;
  - latch b, or ~b when sub=1;
  - set the carry register to sub;
  - clear the digit counter;
  - enter RUN.
REQ-016 Each RUN cycle SHALL add the least-significant DIGIT bits of both operand shift registers plus the carry register, shift the DIGIT-bit sum into the result register from the MSB side, shift both operands right by DIGIT, update carry, and increment the counter.
REQ-017 On the edge that completes digit NDIG-1, the FSM SHALL enter DONE, with sum = (a ± b) mod 2^WIDTH, cout = the final carry, and ovf = (carry into bit WIDTH-1) XOR (carry out of bit WIDTH-1).
REQ-018 done SHALL be high exactly in the DONE cycle, i.e. the cycle after the NDIG-th rising edge following the start-sampling edge; busy SHALL be high exactly for the NDIG RUN cycles.
REQ-019 DONE SHALL last one cycle, then go to IDLE, or to RUN if start=1 (back-to-back with no idle cycle).
REQ-020 start asserted in RUN SHALL be ignored, and the operation in progress SHALL be unaffected.
REQ-021 sum, cout and ovf SHALL change only during RUN and hold their final values in DONE and IDLE; they are undefined while busy=1.
REQ-022 Changes on a, b and sub outside the start-sampling edge SHALL have no effect.

Reset
REQ-023 resetn=0 SHALL immediately force IDLE, with busy=0, done=0, sum=0, cout=0, ovf=0, counter=0 and carry=0, independent of clock.
REQ-024 Reset asserted mid-RUN SHALL abandon the operation; after release, no done pulse SHALL occur until a new start is accepted.
REQ-025 The first start SHALL be accepted on the first rising edge after resetn deasserts.

Structure
REQ-026 A shared package SHALL hold the state enumeration (IDLE, RUN, DONE) and the NDIG/counter-width derivation function.
REQ-027 One combinational sub-module, adder_digit, SHALL be instantiated: a DIGIT-bit ripple of full adders with inputs x, y, cin and outputs s, cout, cmsb (carry into the top bit).
REQ-028 ovf SHALL be computed from adder_digit's cmsb and cout on the final digit.

Verification (WIDTH=8, DIGIT=1 unless noted)
REQ-029 start, a=0x7F, b=0x01, sub=0 -> done after 8 edges; sum=0x80, cout=0, ovf=1; busy high exactly 8 cycles.
REQ-030 start, a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0; then a=0x07, b=0x05, sub=1 -> sum=0x02, cout=1, ovf=0.
REQ-031 WIDTH=16, DIGIT=4: a=0xFFFF, b=0x0001, sub=0 -> done after 4 edges; sum=0x0000, cout=1, ovf=0.
REQ-032 start held high continuously: results 0x80 then next operation -> done pulses 9 cycles apart; start pulses during RUN ignored; operands changed mid-RUN do not alter the result.
REQ-033 resetn low for half a cycle at RUN digit 3 -> all outputs 0 immediately; no done until the next start; the next operation 0x10+0x20 -> sum=0x30.
REQ-034 Randomised sweep of 1000 operations over DIGIT in {1,2,4,8} -> sum, cout and ovf match a reference model.
